updown_mmss_counter: RTL and testbench

- Time-keeping datapath for the digital clock. Sits directly downstream of the key-decoding control FSM and consumes its up and pause outputs.
- Divides the system clock into a 1 Hz enable and keeps an MM:SS value in four BCD digits, counting up or down.
- Feeds the seven-segment display drivers.

---
 rtl/updown_mmss_counter.sv | 116 +++++++++++
 tb/tb_updown_mmss_counter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/updown_mmss_counter.sv
// MM:SS up/down time-keeping datapath: a CLK_DIV prescaler produces one count
// step per period and four BCD digits advance or retreat with carry/borrow.
module updown_mmss_counter #(
    parameter int CLK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       pause,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       step,
    output logic       wrap
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    logic [3:0] nxt_sec_ones;
    logic [3:0] nxt_sec_tens;
    logic [3:0] nxt_min_ones;
    logic [3:0] nxt_min_tens;
    logic       nxt_wrap;

    // Next digit values for one step in the current direction; a carry or
    // borrow out of the top digit is the wrap condition.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
        nxt_sec_ones = sec_ones;
        nxt_sec_tens = sec_tens;
        nxt_min_ones = min_ones;
        nxt_min_tens = min_tens;
        nxt_wrap     = 1'b0;
        if (up) begin
            if (sec_ones != 4'd9) begin
                nxt_sec_ones = sec_ones + 4'd1;
            end else begin
                nxt_sec_ones = 4'd0;
                if (sec_tens != 4'd5) begin
                    nxt_sec_tens = sec_tens + 4'd1;
                end else begin
                    nxt_sec_tens = 4'd0;
                    if (min_ones != 4'd9) begin
                        nxt_min_ones = min_ones + 4'd1;
                    end else begin
                        nxt_min_ones = 4'd0;
                        if (min_tens != 4'd5) begin
                            nxt_min_tens = min_tens + 4'd1;
                        end else begin
                            nxt_min_tens = 4'd0;
                            nxt_wrap     = 1'b1;
                        end
                    end
                end
            end
        end else begin
            if (sec_ones != 4'd0) begin
                nxt_sec_ones = sec_ones - 4'd1;
            end else begin
                nxt_sec_ones = 4'd9;
                if (sec_tens != 4'd0) begin
                    nxt_sec_tens = sec_tens - 4'd1;
                end else begin
                    nxt_sec_tens = 4'd5;
                    if (min_ones != 4'd0) begin
                        nxt_min_ones = min_ones - 4'd1;
                    end else begin
                        nxt_min_ones = 4'd9;
                        if (min_tens != 4'd0) begin
                            nxt_min_tens = min_tens - 4'd1;
                        end else begin
                            nxt_min_tens = 4'd5;
                            nxt_wrap     = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Pause freezes div rather than clearing it, so a resumed second keeps
    // the time it had already accumulated.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset || clear) begin
            div      <= '0;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
            step     <= 1'b0;
            wrap     <= 1'b0;
        end else if (pause) begin
            step <= 1'b0;
            wrap <= 1'b0;
        end else if (div == DIV_LAST) begin
            div      <= '0;
            sec_ones <= nxt_sec_ones;
            sec_tens <= nxt_sec_tens;
            min_ones <= nxt_min_ones;
            min_tens <= nxt_min_tens;
            step     <= 1'b1;
            wrap     <= nxt_wrap;
        end else begin
            div  <= div + 1'b1;
            step <= 1'b0;
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_mmss_counter.sv
// Directed bench for updown_mmss_counter with CLK_DIV=4; expected digits are
// written as BCD constants {min_tens, min_ones, sec_tens, sec_ones}.
module tb_updown_mmss_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       up = 1'b1;
    logic       pause = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       step, wrap;

    int n_checks = 0;
    int n_fail   = 0;

    updown_mmss_counter #(.CLK_DIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .up       (up),
        .pause    (pause),
        .clear    (clear),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .min_ones (min_ones),
        .min_tens (min_tens),
        .step     (step),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    wire [15:0] digits = {min_tens, min_ones, sec_tens, sec_ones};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Run one full prescaler period and verify the step lands on its last edge.
    task automatic one_step(input string tag, input logic [15:0] exp_digits, input logic exp_wrap);
        cycle(3);
        check({tag, " quiet"}, {15'd0, step}, 16'd0);
        cycle(1);
        check({tag, " step"}, {15'd0, step}, 16'd1);
        check({tag, " wrap"}, {15'd0, wrap}, {15'd0, exp_wrap});
        check({tag, " digits"}, digits, exp_digits);
    endtask

    task automatic run_steps(input int n);
        cycle(4 * n);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle(1);
        clear = 1'b0;
    endtask

    initial begin
        cycle(2);
        reset = 1'b0;
        check("reset digits", digits, 16'h0000);
        check("reset flags", {14'd0, step, wrap}, 16'd0);

        // First step after 4 edges, then 9 more to 00:10.
        one_step("first", 16'h0001, 1'b0);
        for (int i = 2; i <= 9; i++) cycle(4);
        check("nine", digits, 16'h0009);
        one_step("ten", 16'h0010, 1'b0);

        // Count up to 59:58, then cross the wrap.
        run_steps(3588);
        check("preload", digits, 16'h5958);
        one_step("to5959", 16'h5959, 1'b0);
        one_step("upwrap", 16'h0000, 1'b1);
        cycle(1);
        check("wrap drop", {14'd0, step, wrap}, 16'd0);

        // Down counting through 00:00 and a minute borrow.
        do_clear();
        check("clear zero", digits, 16'h0000);
        run_steps(2);
        check("at0002", digits, 16'h0002);
        up = 1'b0;
        one_step("dn0001", 16'h0001, 1'b0);
        one_step("dn0000", 16'h0000, 1'b0);
        one_step("dnwrap", 16'h5959, 1'b1);
        up = 1'b1;
        do_clear();
        run_steps(60);
        check("at0100", digits, 16'h0100);
        up = 1'b0;
        one_step("borrow", 16'h0059, 1'b0);

        // Pause mid-second (div=2): frozen, then resumes after 2 more cycles.
        cycle(2);
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle(1);
            check("paused step", {15'd0, step}, 16'd0);
            check("paused digits", digits, 16'h0059);
        end
        pause = 1'b0;
        cycle(1);
        check("resume early", {15'd0, step}, 16'd0);
        cycle(1);
        check("resume step", {15'd0, step}, 16'd1);
        check("resume digits", digits, 16'h0058);

        // Pause over the step edge: step deferred to the first unpaused edge.
        cycle(3);
        pause = 1'b1;
        cycle(3);
        check("held step", {15'd0, step}, 16'd0);
        check("held digits", digits, 16'h0058);
        pause = 1'b0;
        cycle(1);
        check("deferred step", {15'd0, step}, 16'd1);
        check("deferred digits", digits, 16'h0057);

        // Direction change one cycle before the step edge.
        up = 1'b1;
        do_clear();
        run_steps(5);
        check("at0005", digits, 16'h0005);
        cycle(3);
        up = 1'b0;
        cycle(1);
        check("toggle step", {15'd0, step}, 16'd1);
        check("toggle digits", digits, 16'h0004);
        one_step("after toggle", 16'h0003, 1'b0);

        // Clear beats pause and a due step at 12:34.
        up = 1'b1;
        do_clear();
        run_steps(754);
        check("at1234", digits, 16'h1234);
        cycle(3);
        pause = 1'b1;
        clear = 1'b1;
        cycle(1);
        check("clr digits", digits, 16'h0000);
        check("clr flags", {14'd0, step, wrap}, 16'd0);
        clear = 1'b0;
        pause = 1'b0;
        one_step("post clear", 16'h0001, 1'b0);

        // Reset mid-count.
        cycle(2);
        reset = 1'b1;
        cycle(1);
        check("mid reset digits", digits, 16'h0000);
        check("mid reset flags", {14'd0, step, wrap}, 16'd0);
        reset = 1'b0;
        one_step("post reset", 16'h0001, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
